hazard_ctrl: RTL and testbench

- Pipeline hazard controller that drives the `Stall`/`Flush` inputs of every pipeline register and the E-stage forwarding selects.
- Its `StallE` output is the hold input of the D→E pipeline register.
- Combines combinational hazard detection (load-use, taken branch/jump, forwarding) with a small FSM that freezes the pipeline while a data-memory access in M is not ready.
- Also provides a bus-timeout error and a stall-cycle performance counter.

---
 rtl/hazard_ctrl_pkg.sv | 31 +++
 rtl/hazard_ctrl_if.sv | 46 ++++
 rtl/hazard_ctrl_forward.sv | 23 ++
 rtl/hazard_ctrl.sv | 124 ++++++++++++
 tb/tb_hazard_ctrl.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline encodings for the hazard controller: result-source codes,
// forwarding selects and controller FSM states.
package pipeline_pkg;

  localparam int REG_AW = 5;

  localparam logic [1:0] RESULT_ALU = 2'b00;
  localparam logic [1:0] RESULT_MEM = 2'b01;
  localparam logic [1:0] RESULT_PC4 = 2'b10;
  localparam logic [1:0] RESULT_IMM = 2'b11;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_t;

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    MEM_WAIT = 2'b01,
    ERR      = 2'b10
  } hz_state_t;

  // A later stage can supply rs only if it writes a real register (x0 never forwards).
  function automatic logic reg_match(input logic we,
                                     input logic [REG_AW-1:0] rd,
                                     input logic [REG_AW-1:0] rs);
    return we && (rd != '0) && (rd == rs);
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline <-> hazard controller signal bundle. The pipeline (master) supplies
// register/control fields; the controller (slave) returns stalls, flushes and selects.
interface hazard_ctrl_if;
  import pipeline_pkg::*;

  logic [REG_AW-1:0] Rs1D;
  logic [REG_AW-1:0] Rs2D;
  logic [REG_AW-1:0] Rs1E;
  logic [REG_AW-1:0] Rs2E;
  logic [REG_AW-1:0] RdE;
  logic              RegWriteE;
  logic [1:0]        ResultSrcE;
  logic              PCSrcE;
  logic [REG_AW-1:0] RdM;
  logic              RegWriteM;
  logic [REG_AW-1:0] RdW;
  logic              RegWriteW;
  logic              MemReqM;
  logic              MemReadyM;

  logic              StallF;
  logic              StallD;
  logic              StallE;
  logic              StallM;
  logic              FlushD;
  logic              FlushE;
  fwd_sel_t          ForwardAE;
  fwd_sel_t          ForwardBE;
  logic              MemErr;
  logic [31:0]       StallCount;

  modport master (
    output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RegWriteE, ResultSrcE, PCSrcE,
           RdM, RegWriteM, RdW, RegWriteW, MemReqM, MemReadyM,
    input  StallF, StallD, StallE, StallM, FlushD, FlushE,
           ForwardAE, ForwardBE, MemErr, StallCount
  );

  modport slave (
    input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RegWriteE, ResultSrcE, PCSrcE,
           RdM, RegWriteM, RdW, RegWriteW, MemReqM, MemReadyM,
    output StallF, StallD, StallE, StallM, FlushD, FlushE,
           ForwardAE, ForwardBE, MemErr, StallCount
  );

endinterface

// File: rtl/hazard_ctrl_forward.sv
// E-stage operand forwarding selects for both ALU operands; M has priority
// over W because it holds the younger result.
module forward_unit
  import pipeline_pkg::*;
(
  input  logic [1:0][REG_AW-1:0] rs_e,
  input  logic [REG_AW-1:0]      rd_m,
  input  logic                   reg_write_m,
  input  logic [REG_AW-1:0]      rd_w,
  input  logic                   reg_write_w,
  output fwd_sel_t [1:0]         fwd_sel
);

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_operand
      assign fwd_sel[gi] = reg_match(reg_write_m, rd_m, rs_e[gi]) ? FWD_M :
                           reg_match(reg_write_w, rd_w, rs_e[gi]) ? FWD_W :
                                                                    FWD_RF;
    end
  endgenerate

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: memory-wait FSM with timeout, stall/flush priority
// (memstall > redirect > load-use) and a saturating stall-cycle counter.
module hazard_ctrl
  import pipeline_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16
)
(
  input logic         clk,
  input logic         rst,
  hazard_ctrl_if.slave hz
);

  localparam int              WCW       = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WCW-1:0]  WAIT_LAST = WCW'(MEM_TIMEOUT - 1);

  hz_state_t      state_reg;
  logic [WCW-1:0] wait_cnt_reg;
  logic [31:0]    stall_cnt_reg;

  logic memstall;
  logic redirect;
  logic loaduse;
  logic stall_f;
  logic stall_d;
  logic stall_e;
  logic stall_m;
  logic flush_d;
  logic flush_e;

  logic [1:0][REG_AW-1:0] rs_e;
  fwd_sel_t [1:0]         fwd_sel;

  assign rs_e[0] = hz.Rs1E;
  assign rs_e[1] = hz.Rs2E;

  forward_unit u_forward (
    .rs_e        (rs_e),
    .rd_m        (hz.RdM),
    .reg_write_m (hz.RegWriteM),
    .rd_w        (hz.RdW),
    .reg_write_w (hz.RegWriteW),
    .fwd_sel     (fwd_sel)
  );

  assign hz.ForwardAE = fwd_sel[0];
  assign hz.ForwardBE = fwd_sel[1];

  // Once waiting, only MemReadyM releases the stall; MemReqM is not re-checked.
  always_comb begin
    memstall = 1'b0;
    case (state_reg)
      RUN:      memstall = hz.MemReqM && !hz.MemReadyM;
      MEM_WAIT: memstall = !hz.MemReadyM;
      ERR:      memstall = 1'b1;
      default:  memstall = 1'b0;
    endcase
  end

  assign redirect = hz.PCSrcE && !memstall;
  assign loaduse  = hz.RegWriteE && (hz.ResultSrcE == RESULT_MEM) && (hz.RdE != '0) &&
                    ((hz.RdE == hz.Rs1D) || (hz.RdE == hz.Rs2D));

  always_comb begin
    stall_f = 1'b0;
    stall_d = 1'b0;
    stall_e = 1'b0;
    stall_m = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    if (rst) begin
      flush_d = 1'b1;
      flush_e = 1'b1;
    end else if (memstall) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      stall_e = 1'b1;
      stall_m = 1'b1;
    end else if (redirect) begin
      flush_d = 1'b1;
      flush_e = 1'b1;
    end else if (loaduse) begin
      // Hold F/D and inject a bubble into E so the load reaches M first.
      stall_f = 1'b1;
      stall_d = 1'b1;
      flush_e = 1'b1;
    end
  end

  assign hz.StallF     = stall_f;
  assign hz.StallD     = stall_d;
  assign hz.StallE     = stall_e;
  assign hz.StallM     = stall_m;
  assign hz.FlushD     = flush_d;
  assign hz.FlushE     = flush_e;
  assign hz.MemErr     = (state_reg == ERR);
  assign hz.StallCount = stall_cnt_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= RUN;
      wait_cnt_reg  <= '0;
      stall_cnt_reg <= '0;
    end else begin
      if (stall_f && (stall_cnt_reg != 32'hFFFF_FFFF)) begin
        stall_cnt_reg <= stall_cnt_reg + 32'd1;
      end
      case (state_reg)
        RUN, MEM_WAIT: begin
          if (memstall) begin
            wait_cnt_reg <= wait_cnt_reg + 1'b1;
            state_reg    <= (wait_cnt_reg == WAIT_LAST) ? ERR : MEM_WAIT;
          end else begin
            wait_cnt_reg <= '0;
            state_reg    <= RUN;
          end
        end
        ERR:     state_reg <= ERR;
        default: state_reg <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed scenarios then random traffic,
// each cycle's expectation from a behavioural model, checked by a separate monitor.
module tb_hazard_ctrl;
  import pipeline_pkg::*;

  localparam int T = 4;

  typedef struct {
    logic [3:0]  stall;   // {F, D, E, M}
    logic [1:0]  flush;   // {D, E}
    logic [1:0]  fa;
    logic [1:0]  fb;
    logic        err;
    logic [31:0] sc;
    logic        ms;
    logic        rst_in;
    logic        req;
    logic        rdy;
  } exp_t;

  logic clk;
  logic rst;
  hazard_ctrl_if hif ();

  hazard_ctrl #(.MEM_TIMEOUT(T)) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hif.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  exp_t expq[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  // Behavioural model state: sticky error, an access outstanding, consecutive
  // stalled-memory cycles seen so far, and the stall counter.
  bit          m_err;
  bit          m_outstanding;
  int          m_wait;
  logic [31:0] m_sc;

  function automatic logic [1:0] fwd(input logic [4:0] rs);
    if (hif.RegWriteM && hif.RdM != 0 && hif.RdM == rs) return 2'b10;
    if (hif.RegWriteW && hif.RdW != 0 && hif.RdW == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic exp_t predict();
    exp_t e;
    bit   lu;
    e.ms = m_err || (m_outstanding ? !hif.MemReadyM : (hif.MemReqM && !hif.MemReadyM));
    lu   = hif.RegWriteE && hif.ResultSrcE == 2'b01 && hif.RdE != 0 &&
           (hif.RdE == hif.Rs1D || hif.RdE == hif.Rs2D);
    e.fa = fwd(hif.Rs1E);
    e.fb = fwd(hif.Rs2E);
    e.err = m_err;
    e.sc  = m_sc;
    e.rst_in = rst;
    e.req = hif.MemReqM;
    e.rdy = hif.MemReadyM;
    if (rst)              begin e.stall = 4'b0000; e.flush = 2'b11; end
    else if (e.ms)        begin e.stall = 4'b1111; e.flush = 2'b00; end
    else if (hif.PCSrcE)  begin e.stall = 4'b0000; e.flush = 2'b11; end
    else if (lu)          begin e.stall = 4'b1100; e.flush = 2'b01; end
    else                  begin e.stall = 4'b0000; e.flush = 2'b00; end
    return e;
  endfunction

  task automatic model_edge(input exp_t e);
    if (e.rst_in) begin
      m_err = 0; m_outstanding = 0; m_wait = 0; m_sc = 32'd0;
    end else begin
      if (e.stall[3] && m_sc != 32'hFFFF_FFFF) m_sc = m_sc + 32'd1;
      if (!m_err) begin
        if (e.ms) begin
          if (m_wait == T - 1) m_err = 1;
          else begin m_outstanding = 1; m_wait++; end
        end else begin
          m_outstanding = 0; m_wait = 0;
        end
      end
    end
  endtask

  // Called just after a rising edge with inputs already set for this cycle.
  task automatic cycle();
    exp_t e;
    e = predict();
    expq.push_back(e);
    @(posedge clk);
    model_edge(e);
    #1;
  endtask

  task automatic set_idle();
    hif.Rs1D = 0; hif.Rs2D = 0; hif.Rs1E = 0; hif.Rs2E = 0; hif.RdE = 0;
    hif.RegWriteE = 0; hif.ResultSrcE = 2'b00; hif.PCSrcE = 0;
    hif.RdM = 0; hif.RegWriteM = 0; hif.RdW = 0; hif.RegWriteW = 0;
    hif.MemReqM = 0; hif.MemReadyM = 0;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, req);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      cyc++;
      $display("cyc %0d rst=%0d req=%0d rdy=%0d stall=%b flush=%b fa=%0d fb=%0d err=%0d sc=%h",
               cyc, e.rst_in, e.req, e.rdy,
               {hif.StallF, hif.StallD, hif.StallE, hif.StallM},
               {hif.FlushD, hif.FlushE}, hif.ForwardAE, hif.ForwardBE,
               hif.MemErr, hif.StallCount);
      chk("stalls", {28'd0, hif.StallF, hif.StallD, hif.StallE, hif.StallM}, {28'd0, e.stall});
      chk("flushes", {30'd0, hif.FlushD, hif.FlushE}, {30'd0, e.flush});
      chk("fwd_a", {30'd0, hif.ForwardAE}, {30'd0, e.fa});
      chk("fwd_b", {30'd0, hif.ForwardBE}, {30'd0, e.fb});
      chk("mem_err", {31'd0, hif.MemErr}, {31'd0, e.err});
      chk("stall_count", hif.StallCount, e.sc);
    end
  end

  initial begin
    rst = 1'b1;
    set_idle();
    m_err = 0; m_outstanding = 0; m_wait = 0; m_sc = 32'd0;
    @(posedge clk);
    #1;

    // Reset cycle: no stalls, both flushes
    cycle();
    rst = 1'b0;

    // Load-use on Rs1D, then bubble, then RdE = x0 (no stall)
    hif.RegWriteE = 1; hif.ResultSrcE = 2'b01; hif.RdE = 5; hif.Rs1D = 5;
    cycle();
    hif.RegWriteE = 0; hif.RdE = 0;
    cycle();
    hif.RegWriteE = 1; hif.RdE = 0; hif.Rs1D = 0;
    cycle();
    hif.RdE = 9; hif.Rs2D = 9; hif.Rs1D = 3;
    cycle();
    set_idle();

    // Forwarding priority and x0
    hif.RdM = 7; hif.RdW = 7; hif.RegWriteM = 1; hif.RegWriteW = 1; hif.Rs1E = 7;
    cycle();
    hif.RegWriteM = 0;
    cycle();
    hif.RdW = 0; hif.Rs2E = 0;
    cycle();
    hif.Rs2E = 7; hif.RegWriteM = 1;
    cycle();
    set_idle();

    // Redirect beats load-use
    hif.RegWriteE = 1; hif.ResultSrcE = 2'b01; hif.RdE = 5; hif.Rs1D = 5; hif.PCSrcE = 1;
    cycle();
    set_idle();

    // Memory wait of 3 cycles with a branch held in E
    hif.MemReqM = 1; hif.MemReadyM = 0; hif.PCSrcE = 1;
    repeat (3) cycle();
    hif.MemReadyM = 1;
    cycle();
    set_idle();
    cycle();

    // Ready arrives on the timeout cycle: no error
    hif.MemReqM = 1;
    repeat (T - 1) cycle();
    hif.MemReadyM = 1;
    cycle();
    set_idle();
    cycle();

    // Timeout into ERR, then reset
    hif.MemReqM = 1;
    repeat (T + 2) cycle();
    hif.MemReadyM = 1;
    cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    set_idle();
    cycle();

    // Reset mid-wait: next cycle is RUN even with MemReadyM low
    hif.MemReqM = 1;
    repeat (2) cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    hif.MemReqM = 0;
    repeat (2) cycle();

    // StallCount saturation
    force dut.stall_cnt_reg = 32'hFFFF_FFFD;
    #1;
    release dut.stall_cnt_reg;
    m_sc = 32'hFFFF_FFFD;
    hif.MemReqM = 1; hif.MemReadyM = 0;
    repeat (T) cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    set_idle();

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      rst = ($urandom_range(0, 39) == 0);
      hif.Rs1D = 5'($urandom_range(0, 3));
      hif.Rs2D = 5'($urandom_range(0, 3));
      hif.Rs1E = 5'($urandom_range(0, 3));
      hif.Rs2E = 5'($urandom_range(0, 3));
      hif.RdE  = 5'($urandom_range(0, 3));
      hif.RdM  = 5'($urandom_range(0, 3));
      hif.RdW  = 5'($urandom_range(0, 3));
      hif.RegWriteE  = 1'($urandom_range(0, 1));
      hif.RegWriteM  = 1'($urandom_range(0, 1));
      hif.RegWriteW  = 1'($urandom_range(0, 1));
      hif.ResultSrcE = 2'($urandom_range(0, 3));
      hif.PCSrcE     = ($urandom_range(0, 3) == 0);
      hif.MemReqM    = ($urandom_range(0, 2) == 0);
      hif.MemReadyM  = ($urandom_range(0, 9) < 6);
      cycle();
    end
    rst = 1'b0;
    set_idle();

    for (int i = 0; i < 4 && expq.size() != 0; i++) @(negedge clk);
    #1;
    chk("scoreboard_drain", 32'(expq.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
